// File: rtl/shifter_pkg.sv
// Shared definitions for the serial left shifter: FSM state encoding and
// the default data/counter widths used by the top level and the encoder.
package shifter_pkg;

  // Default data width and the matching shift-count width.
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  // Controller states: waiting, shifting one bit per cycle, result ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : shifter_pkg

// File: rtl/lsb_priority_enc.sv
// Lowest-set-bit priority encoder. Returns the index of the least
// significant 1 in vec_i; bit 0 has the highest priority and any higher
// set bits are ignored. valid_o is low when vec_i is all zeros, in which
// case idx_o reads as 0.
module lsb_priority_enc
  import shifter_pkg::*;
#(
  parameter int WIDTH = shifter_pkg::WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from the top bit down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule : lsb_priority_enc

// File: rtl/serial_left_shifter.sv
// Serial left shifter. On an accepted start the operand d is captured and
// shifted left one bit per clock, k times, where k is the index of the
// lowest set bit of n. Bits leaving the top are OR-ed into an overflow
// flag. busy is high while shifting; done pulses for one cycle when w and
// ovf are valid, and both hold until the next accepted start.
module serial_left_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = shifter_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] w,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CW-1:0]    k_idx;
  logic             k_valid;
  logic             accept;

  lsb_priority_enc #(
    .WIDTH (WIDTH),
    .IDX_W (CW)
  ) u_enc (
    .vec_i   (n),
    .idx_o   (k_idx),
    .valid_o (k_valid)
  );

  // A new request is only taken while not shifting, so an in-flight
  // operation can never be disturbed by start.
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  // Next-state logic: load on accept, shift while the counter is nonzero,
  // then spend exactly one cycle in DONE. A zero selector loads a zero
  // operand so the result is 0 with no overflow.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          acc_d   = k_valid ? d : '0;
          cnt_d   = k_valid ? k_idx : '0;
          ovf_d   = 1'b0;
        end
      end

      SHIFT: begin
        if (cnt_q != '0) begin
          acc_d = acc_q << 1;
          ovf_d = ovf_q | acc_q[WIDTH-1];
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (accept) begin
          state_d = SHIFT;
          acc_d   = k_valid ? d : '0;
          cnt_d   = k_valid ? k_idx : '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // All state lives here; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign w    = acc_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule : serial_left_shifter

// File: tb/tb_serial_left_shifter.sv
// Self-checking bench for serial_left_shifter. Expected results come from
// a reference model that computes d << k with 32-bit arithmetic and takes
// k as the position of the isolated lowest set bit of n.
module tb_serial_left_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] d;
  logic [15:0] n;
  logic [15:0] w;
  logic        busy;
  logic        done;
  logic        ovf;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  serial_left_shifter #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .d     (d),
    .n     (n),
    .w     (w),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  // Reference model: result, overflow and shift amount for one operation.
  function automatic void refModel(input logic [15:0] dIn, input logic [15:0] nIn,
                                   output logic [15:0] wExp, output logic ovfExp,
                                   output int kExp);
    logic [31:0] lowest;
    logic [31:0] full;
    if (nIn == 16'h0000) begin
      wExp   = 16'h0000;
      ovfExp = 1'b0;
      kExp   = 0;
    end else begin
      lowest = {16'h0000, nIn & (~nIn + 16'd1)};
      kExp   = $clog2(lowest);
      full   = {16'h0000, dIn} << kExp;
      wExp   = full[15:0];
      ovfExp = |full[31:16];
    end
  endfunction

  // One comparison: counts it, and reports the tag and both values on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one operation from just after a falling edge. intrudeAt > 0 pulses a
  // competing start (d=FFFF, n=0001) at that sample while busy. chainAfter
  // returns right at the done sample so the caller can start again in the
  // done cycle.
  task automatic applyStimulus(input string tag, input logic [15:0] dIn,
                               input logic [15:0] nIn, input int intrudeAt,
                               input bit chainAfter);
    logic [15:0] wExp;
    logic        ovfExp;
    int          kExp;
    int          lat;
    int          busyCnt;
    int          clash;
    refModel(dIn, nIn, wExp, ovfExp, kExp);
    lat     = 0;
    busyCnt = 0;
    clash   = 0;
    start = 1'b1;
    d     = dIn;
    n     = nIn;
    @(posedge clk);
    #1;
    start = 1'b0;
    d     = 16'($urandom);
    n     = 16'($urandom);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) checkOutput({tag, ".busyFirst"}, 32'(busy), 32'd1);
      if (busy) busyCnt++;
      if (busy && done) clash++;
      if (intrudeAt > 0 && i == intrudeAt) begin
        start = 1'b1;
        d     = 16'hFFFF;
        n     = 16'h0001;
      end
      if (intrudeAt > 0 && i == intrudeAt + 1) start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'(kExp + 2));
    checkOutput({tag, ".busyCycles"}, 32'(busyCnt), 32'(kExp + 1));
    checkOutput({tag, ".busyDoneClash"}, 32'(clash), 32'd0);
    checkOutput({tag, ".w"}, {16'h0000, w}, {16'h0000, wExp});
    checkOutput({tag, ".ovf"}, 32'(ovf), 32'(ovfExp));
    if (!chainAfter) begin
      @(negedge clk);
      checkOutput({tag, ".donePulse"}, 32'(done), 32'd0);
      checkOutput({tag, ".idleBusy"}, 32'(busy), 32'd0);
      checkOutput({tag, ".wHold"}, {16'h0000, w}, {16'h0000, wExp});
      checkOutput({tag, ".ovfHold"}, 32'(ovf), 32'(ovfExp));
    end
  endtask

  initial begin
    int doneSeen;
    logic [15:0] dR;
    logic [15:0] nR;

    rst   = 1'b1;
    start = 1'b0;
    d     = 16'h0000;
    n     = 16'h0000;
    #2;
    checkOutput("reset.w", {16'h0000, w}, 32'h0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed operations");
    applyStimulus("k3", 16'h00F3, 16'h0008, 0, 1'b0);
    applyStimulus("k1ovf", 16'hC000, 16'h0006, 0, 1'b0);
    applyStimulus("k15", 16'h0001, 16'h8000, 0, 1'b0);
    applyStimulus("k0", 16'h8001, 16'h0001, 0, 1'b0);
    applyStimulus("nzero", 16'hFFFF, 16'h0000, 0, 1'b0);
    applyStimulus("ignoreBusy", 16'h0001, 16'h0010, 2, 1'b0);
    applyStimulus("b2bFirst", 16'h0003, 16'h0004, 0, 1'b1);
    applyStimulus("b2bSecond", 16'h00FF, 16'h0002, 0, 1'b0);

    $display("[TB] reset during shift");
    start = 1'b1;
    d     = 16'h1234;
    n     = 16'h0100;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midReset.w", {16'h0000, w}, 32'h0);
    checkOutput("midReset.busy", 32'(busy), 32'd0);
    checkOutput("midReset.done", 32'(done), 32'd0);
    #2;
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("midReset.noDone", 32'(doneSeen), 32'd0);
    checkOutput("midReset.stillIdle", 32'(busy), 32'd0);
    applyStimulus("afterReset", 16'h0A0B, 16'h0030, 0, 1'b0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 12; i++) begin
      dR = 16'($urandom);
      nR = (i % 5 == 4) ? 16'h0000 : 16'($urandom) & 16'($urandom);
      applyStimulus($sformatf("rand%0d", i), dR, nR, 0, (i % 3 == 1));
    end
    applyStimulus("randTail", 16'($urandom), 16'($urandom), 0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_serial_left_shifter
